// File: rtl/pid_pwm_driver.sv
// Sign-magnitude H-bridge PWM driver with double-buffered duty and boundary update.
// Optional dead-time insertion on direction reversal: define PID_PWM_DEADTIME_EN.
module pid_pwm_driver #(
    parameter int unsigned W      = 16,
    parameter int unsigned CW     = 10,
    parameter int unsigned PERIOD = 1000,
    parameter int unsigned DEAD   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic signed [W-1:0] duty_in,
    input  logic                duty_valid,
    output logic                pwm_a,
    output logic                pwm_b,
    output logic                dir,
    output logic                period_start,
    output logic                sat
);

    localparam int unsigned AW = CW + 1;
    localparam int unsigned MW = ((W + 1) > AW) ? (W + 1) : AW;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
    localparam logic [AW-1:0] PMAG = AW'(PERIOD);
    localparam logic [MW-1:0] PLIM = MW'(PERIOD);
`ifdef PID_PWM_DEADTIME_EN
    localparam logic [CW-1:0] DEAD_C = CW'(DEAD);
`endif

    // Elaboration-time parameter sanity check.
    if (PERIOD < 2 || DEAD >= PERIOD || PERIOD > (1 << CW)) begin : g_bad_param
        $error("pid_pwm_driver: illegal PERIOD/DEAD/CW combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1
`ifdef PID_PWM_DEADTIME_EN
        ,
        DEADT = 2'd2
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q;
    logic signed [W-1:0]   shadow_q;
    logic [AW-1:0]         act_mag_q;
    logic                  act_dir_q;
    logic                  act_sat_q;

    logic                  boundary_c;
    logic signed [W-1:0]   new_duty_c;
    logic signed [MW-1:0]  dext_c;
    logic [MW-1:0]         dabs_c;
    logic                  new_sat_c;
    logic [AW-1:0]         new_mag_c;
    logic                  new_dir_c;
    logic                  gate_c;
    logic                  on_c;

    // Next-state, boundary duty decode and output gating.
    always_comb begin
        state_d    = state_q;
        boundary_c = (state_q != IDLE) && (cnt_q == LAST);
        new_duty_c = duty_valid ? duty_in : shadow_q;
        dext_c     = MW'(new_duty_c);
        dabs_c     = dext_c[MW-1] ? $unsigned(-dext_c) : $unsigned(dext_c);
        new_sat_c  = (dabs_c > PLIM);
        new_mag_c  = new_sat_c ? PMAG : AW'(dabs_c);
        new_dir_c  = (new_duty_c == '0) ? act_dir_q : new_duty_c[W-1];
        on_c       = ({1'b0, cnt_q} < act_mag_q);
        gate_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                gate_c = 1'b1;
`ifdef PID_PWM_DEADTIME_EN
                if (boundary_c && (new_dir_c != act_dir_q) && (act_mag_q != '0))
                    state_d = DEADT;
`endif
            end
`ifdef PID_PWM_DEADTIME_EN
            DEADT: begin
                gate_c = (cnt_q >= DEAD_C);
                if (boundary_c)
                    state_d = (new_dir_c != act_dir_q) ? DEADT : RUN;
                else if (cnt_q >= DEAD_C)
                    state_d = RUN;
            end
`endif
            default: state_d = IDLE;
        endcase

        if (!enable) state_d = IDLE;
    end

    // State, counter, duty buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shadow_q     <= '0;
            act_mag_q    <= '0;
            act_dir_q    <= 1'b0;
            act_sat_q    <= 1'b0;
            pwm_a        <= 1'b0;
            pwm_b        <= 1'b0;
            dir          <= 1'b0;
            period_start <= 1'b0;
            sat          <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!enable) begin
                cnt_q     <= '0;
                shadow_q  <= '0;
                act_mag_q <= '0;
                act_dir_q <= 1'b0;
                act_sat_q <= 1'b0;
            end else begin
                if (state_q == IDLE || cnt_q == LAST) cnt_q <= '0;
                else                                  cnt_q <= cnt_q + CW'(1);

                // Last strobe wins; one coincident with the boundary is taken directly.
                if (boundary_c) begin
                    shadow_q  <= new_duty_c;
                    act_mag_q <= new_mag_c;
                    act_dir_q <= new_dir_c;
                    act_sat_q <= new_sat_c;
                end else if (duty_valid) begin
                    shadow_q <= duty_in;
                end
            end

            // Single dir bit selects exactly one leg, so both can never be high together.
            pwm_a        <= enable && gate_c && on_c && !act_dir_q;
            pwm_b        <= enable && gate_c && on_c &&  act_dir_q;
            dir          <= enable && (state_q != IDLE) && act_dir_q;
            sat          <= enable && (state_q != IDLE) && act_sat_q;
            period_start <= enable && (state_q != IDLE) && (cnt_q == '0);
        end
    end

endmodule

// File: tb/tb_pid_pwm_driver.sv
// Directed bench for pid_pwm_driver: period-by-period waveform checks with hand-derived
// expected on-windows; dead-time expectations follow PID_PWM_DEADTIME_EN.
module tb_pid_pwm_driver;

    localparam int W      = 16;
    localparam int CW     = 10;
    localparam int PERIOD = 1000;
    localparam int DEAD   = 8;
`ifdef PID_PWM_DEADTIME_EN
    localparam int DX = DEAD;
`else
    localparam int DX = 0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic signed [W-1:0] duty_in;
    logic                duty_valid;
    logic                pwm_a, pwm_b, dir, period_start, sat;

    int n_checks = 0;
    int n_fail   = 0;

    pid_pwm_driver #(.W(W), .CW(CW), .PERIOD(PERIOD), .DEAD(DEAD)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .pwm_a        (pwm_a),
        .pwm_b        (pwm_b),
        .dir          (dir),
        .period_start (period_start),
        .sat          (sat)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all_low(input string tag);
        logic [4:0] obs;
        obs = {pwm_a, pwm_b, dir, period_start, sat};
        n_checks++;
        assert (obs === 5'b0) else begin
            n_fail++;
            $error("FAIL %s: observed {a,b,dir,ps,sat}=%b expected 00000", tag, obs);
        end
    endtask

    // Entered on the period_start sample (output counter 0); leaves on the next one.
    task automatic check_period(input string tag,
                                input int a_lo, input int a_hi,
                                input int b_lo, input int b_hi,
                                input logic e_dir, input logic e_sat,
                                input int s1, input int v1,
                                input int s2, input int v2);
        int   bad, first_bad, both;
        logic ea, eb, eps;
        bad = 0; first_bad = -1; both = 0;
        check_bit({tag, "_ps"},  period_start, 1'b1);
        check_bit({tag, "_dir"}, dir, e_dir);
        check_bit({tag, "_sat"}, sat, e_sat);
        for (int i = 0; i < PERIOD; i++) begin
            ea  = (i >= a_lo) && (i < a_hi);
            eb  = (i >= b_lo) && (i < b_hi);
            eps = (i == 0);
            if (pwm_a !== ea || pwm_b !== eb || period_start !== eps) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
            if (pwm_a === 1'b1 && pwm_b === 1'b1) both++;
            if (i == s1) begin
                duty_in = W'(v1); duty_valid = 1'b1;
            end else if (i == s2) begin
                duty_in = W'(v2); duty_valid = 1'b1;
            end else begin
                duty_valid = 1'b0;
            end
            step();
        end
        duty_valid = 1'b0;
        n_checks++;
        assert (bad === 0) else begin
            n_fail++;
            $error("FAIL %s_wave: observed %0d bad cycles (first at counter %0d) expected 0",
                   tag, bad, first_bad);
        end
        n_checks++;
        assert (both === 0) else begin
            n_fail++;
            $error("FAIL %s_overlap: observed %0d cycles with both legs high expected 0",
                   tag, both);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; duty_in = '0; duty_valid = 1'b0;
        repeat (3) step();
        check_all_low("reset");

        // Reset dominates enable; first period_start on the second edge after release.
        enable = 1'b1;
        repeat (2) step();
        check_all_low("rst_prio");
        rst = 1'b0;
        step();
        check_all_low("release_edge1");
        step();

        check_period("zero",     -1, -1, -1, -1, 1'b0, 1'b0, 499, 250, -1, 0);
        check_period("p250",      0, 250, -1, -1, 1'b0, 1'b0, 300, -600, -1, 0);
        check_period("n600",     -1, -1, DX, 600, 1'b1, 1'b0, 100, -32768, -1, 0);
        check_period("neg_max",  -1, -1, 0, PERIOD, 1'b1, 1'b1, 700, 1500, -1, 0);
        check_period("p1500",    DX, PERIOD, -1, -1, 1'b0, 1'b1, 499, 100, 998, 300);
        check_period("p300",      0, 300, -1, -1, 1'b0, 1'b0, -1, 0, -1, 0);

        // Disable mid-pulse, then re-enable: duty must come back as zero.
        repeat (100) step();
        check_bit("dis_pre_a", pwm_a, 1'b1);
        enable = 1'b0;
        step();
        check_all_low("dis_drop");
        step();
        enable = 1'b1;
        step();
        check_bit("reen_edge1_ps", period_start, 1'b0);
        step();
        check_period("reen",     -1, -1, -1, -1, 1'b0, 1'b0, 10, 300, -1, 0);
        check_period("p300b",     0, 300, -1, -1, 1'b0, 1'b0, -1, 0, -1, 0);

        // Reset mid-pulse.
        repeat (100) step();
        check_bit("rst_pre_a", pwm_a, 1'b1);
        rst = 1'b1;
        step();
        check_all_low("rst_drop");
        rst = 1'b0;
        step();
        check_bit("rst_rel_edge1_ps", period_start, 1'b0);
        step();
        check_period("after_rst", -1, -1, -1, -1, 1'b0, 1'b0, 5, -50, -1, 0);
        check_period("n50",       -1, -1, 0, 50, 1'b1, 1'b0, 20, 0, -1, 0);
        check_period("zero_keep", -1, -1, -1, -1, 1'b1, 1'b0, 3, 5, -1, 0);
        check_period("p5",         0, 5, -1, -1, 1'b0, 1'b0, 3, -6, -1, 0);
        check_period("n6",        -1, -1, DX, 6, 1'b1, 1'b0, -1, 0, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pid_pwm_driver.md
PID_PWM_DRIVER -- requirements
Module: pid_pwm_driver

Interface
REQ-001 Parameter: W, 16, signed duty input width.
REQ-002 Parameter: CW, 10, period counter width.
REQ-003 Parameter: PERIOD, 1000, PWM period in clk cycles; 2 <= PERIOD <= 2^CW.
REQ-004 Parameter: DEAD, 8, dead-time in clk cycles; DEAD < PERIOD.
REQ-005 clk  in  1  single block clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 enable  in  1  drive enable; low forces coast.
REQ-008 duty_in  in  W  signed two's-complement command; sign selects direction, magnitude selects on-time in cycles.
REQ-009 duty_valid  in  1  duty_in qualifier; single-cycle strobe, no backpressure.
REQ-010 pwm_a  out  1  forward-leg gate, registered.
REQ-011 pwm_b  out  1  reverse-leg gate, registered.
REQ-012 dir  out  1  active direction: 0 forward, 1 reverse, registered.
REQ-013 period_start  out  1  one-cycle pulse when the counter equals 0, registered.
REQ-014 sat  out  1  high while the active magnitude is clipped to PERIOD, registered.

Function
REQ-015 FSM states: IDLE, RUN, DEADT.
- IDLE: counter held at 0, shadow duty cleared, outputs low.
- IDLE->RUN when enable=1; counter starts at 0 on the next cycle.
REQ-016 Any state -> IDLE on the cycle after enable=0; pwm_a/pwm_b are low from that cycle.
REQ-017 In RUN/DEADT the counter runs 0..PERIOD-1 and wraps to 0; period_start=1 exactly when the counter is 0.
REQ-018 A duty_valid strobe with enable=1 latches duty_in into the shadow register; the last strobe before the boundary wins.
REQ-019 At counter==PERIOD-1 the shadow value is transferred to the active register and takes effect from the following counter==0.
- Latency from strobe to output: at most one full period plus one cycle.
REQ-020 A duty_valid strobe coincident with counter==PERIOD-1 is applied at that same boundary.
REQ-021 Magnitude = |duty|, computed in W+1 bits, saturated to PERIOD.
- sat=1 when |duty| > PERIOD.
- The most negative value (-2^(W-1)) saturates and does not overflow.
REQ-022 dir=1 iff active duty < 0; duty 0 keeps the previous dir.
REQ-023 RUN outputs:
- pwm_a = (dir==0) && (counter < mag).
- pwm_b = (dir==1) && (counter < mag).
- mag==PERIOD gives 100% on-time; mag==0 gives constant low.
REQ-024 pwm_a and pwm_b SHALL never be high in the same cycle, under any input sequence.
REQ-025 RUN->DEADT at a boundary where dir changes and the previous active magnitude was nonzero.
- DEADT: both outputs low while counter < DEAD, then RUN.
- If mag <= DEAD, that period produces no pulse.
REQ-026 A dir change while already in DEADT restarts the dead window at the next counter==0.

Reset
REQ-027 While rst=1: state IDLE, counter 0, shadow and active duty 0, dir 0.
- Outputs pwm_a, pwm_b, period_start and sat are all 0.
REQ-028 rst has priority over enable and duty_valid; reset mid-period drops both outputs on the next clk edge.
REQ-029 After rst deasserts with enable=1, the first period_start occurs on the second clk edge after deassertion.

Configuration
REQ-030 Macro PID_PWM_DEADTIME_EN.
- Defined: DEADT state and REQ-025/026 are implemented.
- Undefined: DEADT is absent; direction changes take effect at the boundary with no dead window. REQ-024 still holds.

Verification
REQ-031 PERIOD=1000, duty_in=+250 strobed mid-period -> from the next period_start, pwm_a high for counter 0..249; pwm_b=0; sat=0.
REQ-032 duty_in=+250 then -600 -> at the boundary dir=1, both outputs low for counter 0..7, then pwm_b high for 8..599 (DEADTIME_EN defined); pwm_b high for 0..599 when undefined.
REQ-033 duty_in=-32768 and duty_in=+1500 -> mag=1000, output high for the full period, sat=1 in both cases.
REQ-034 Strobes +100 at counter 500 and +300 at counter 999 -> next period uses 300; the +100 is never output.
REQ-035 enable=0 or rst=1 at counter 100 with pwm_a high -> pwm_a=0 on the next edge, counter=0; re-enable gives zero duty until a new strobe is applied.
